// File: rtl/signed_mac_requant.sv
// Signed product accumulator with int8 requantization.
// Sums N_TERMS products onto a bias, then rounds, shifts, clamps and emits one result.
module signed_mac_requant #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 16,
  parameter int SHIFT   = 4,
  parameter int RELU    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  input  logic [PROD_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_sat
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(2 ** (SHIFT - 1));
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] MINV = -(ACC_W+1)'(128);

  typedef enum logic {ACC, OUT} state_t;

  state_t state, state_nx;
  logic [CNT_W-1:0] term_cnt;
  logic signed [ACC_W-1:0] acc, base, sum;
  logic signed [ACC_W-1:0] bias_x, prod_x;
  logic signed [ACC_W:0] rnd, rq;
  logic fire, first, last;
  logic [7:0] q_data;
  logic q_sat;

  assign bias_x = {{(ACC_W-PROD_W){bias[PROD_W-1]}}, bias};
  assign prod_x = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  assign fire  = in_valid && in_ready && !clear;
  assign first = (term_cnt == '0);
  assign last  = (term_cnt == LAST);
  assign base  = first ? bias_x : acc;
  assign sum   = base + prod_x;
  // one extra bit keeps the rounding add from wrapping
  assign rnd   = {sum[ACC_W-1], sum} + HALF;

  always_comb begin
    rq = rnd >>> SHIFT;
    if (RELU != 0 && rq[ACC_W]) rq = '0;
    q_data = rq[7:0];
    q_sat  = 1'b0;
    if (rq > MAXV) begin
      q_data = 8'h7F;
      q_sat  = 1'b1;
    end else if (rq < MINV) begin
      q_data = 8'h80;
      q_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = ACC;
    end else begin
      case (state)
        ACC: if (fire && last) state_nx = OUT;
        OUT: if (out_ready)    state_nx = ACC;
        default: state_nx = ACC;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_cnt <= '0;
      acc      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (clear) begin
      term_cnt <= '0;
    end else if (fire) begin
      acc      <= sum;
      term_cnt <= last ? '0 : term_cnt + 1'b1;
      if (last) begin
        out_data <= q_data;
        out_sat  <= q_sat;
      end
    end
  end

endmodule

// File: tb/tb_signed_mac_requant.sv
// Directed scoreboard bench for signed_mac_requant.
// Three instances: N_TERMS=4, N_TERMS=1, and N_TERMS=4 with ReLU.
module tb_signed_mac_requant;

  logic clk, rst_n;
  logic clear [3];
  logic in_valid [3];
  logic in_ready [3];
  logic [15:0] prod [3];
  logic [15:0] bias [3];
  logic out_valid [3];
  logic out_ready [3];
  logic [7:0] out_data [3];
  logic out_sat [3];

  typedef struct packed {
    logic [7:0] d;
    logic s;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp, n_bad;

  signed_mac_requant #(.N_TERMS(4), .SHIFT(4), .RELU(0)) u_main (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .prod(prod[0]), .bias(bias[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_sat(out_sat[0]));

  signed_mac_requant #(.N_TERMS(1), .SHIFT(4), .RELU(0)) u_n1 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .prod(prod[1]), .bias(bias[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_sat(out_sat[1]));

  signed_mac_requant #(.N_TERMS(4), .SHIFT(4), .RELU(1)) u_relu (
    .clk(clk), .rst_n(rst_n), .clear(clear[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .prod(prod[2]), .bias(bias[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_sat(out_sat[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int d, input logic [15:0] b,
                      input logic [15:0] p);
    in_valid[d] = 1'b1;
    bias[d] = b;
    prod[d] = p;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic dot(input int d, input logic [15:0] b,
                     input logic [15:0] p0, input logic [15:0] p1,
                     input logic [15:0] p2, input logic [15:0] p3,
                     input int n, input logic [7:0] ed, input logic es);
    exp_t e;
    e.d = ed;
    e.s = es;
    exp_q.push_back(e);
    beat(d, b, p0);
    if (n > 1) begin
      beat(d, b, p1);
      beat(d, b, p2);
      beat(d, b, p3);
    end
    chk("latency", 32'(out_valid[d]), 32'd1);
  endtask

  task automatic take(input int d, input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(out_data[d]), 32'(e.d));
      chk({tag, "_sat"}, 32'(out_sat[d]), 32'(e.s));
    end
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    chk({tag, "_ovdrop"}, 32'(out_valid[d]), 32'd0);
    chk({tag, "_irdy"}, 32'(in_ready[d]), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clear[i] = 1'b0;
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
      prod[i] = '0;
      bias[i] = '0;
    end
    #3;
    chk("rst_ovalid", 32'(out_valid[0]), 32'd0);
    chk("rst_data", 32'(out_data[0]), 32'd0);
    chk("rst_sat", 32'(out_sat[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_irdy", 32'(in_ready[0]), 32'd1);

    dot(0, 16'd0, 16'hFFCE, 16'hFFCE, 16'hFFCE, 16'hFFCE, 4, 8'hF4, 1'b0);
    take(0, "neg_round");
    dot(0, 16'd16384, 16'd300, 16'd300, 16'd300, 16'd300, 4, 8'h7F, 1'b1);
    take(0, "pos_sat");
    dot(0, 16'd0, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 4, 8'h80, 1'b1);
    take(0, "neg_sat");

    dot(1, 16'd0, 16'd8, 16'd0, 16'd0, 16'd0, 1, 8'h01, 1'b0);
    take(1, "n1_p8");
    dot(1, 16'd0, 16'd7, 16'd0, 16'd0, 16'd0, 1, 8'h00, 1'b0);
    take(1, "n1_p7");
    dot(1, 16'd0, 16'hFFF8, 16'd0, 16'd0, 16'd0, 1, 8'h00, 1'b0);
    take(1, "n1_m8");
    dot(1, 16'd0, 16'hFFF7, 16'd0, 16'd0, 16'd0, 1, 8'hFF, 1'b0);
    take(1, "n1_m9");

    dot(2, 16'd0, 16'hFFCE, 16'hFFCE, 16'hFFCE, 16'hFFCE, 4, 8'h00, 1'b0);
    take(2, "relu");

    // 100 + 4*10 = 140 -> (140+8)>>4 = 9, offered beat during OUT must be ignored
    dot(0, 16'd100, 16'd10, 16'd10, 16'd10, 16'd10, 4, 8'h09, 1'b0);
    in_valid[0] = 1'b1;
    prod[0] = 16'd1000;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ovalid", 32'(out_valid[0]), 32'd1);
      chk("bp_data", 32'(out_data[0]), 32'h09);
      chk("bp_irdy", 32'(in_ready[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    take(0, "bp");
    dot(0, 16'd0, 16'd16, 16'd16, 16'd16, 16'd16, 4, 8'h04, 1'b0);
    take(0, "bp_next");

    beat(0, 16'd0, 16'd1000);
    beat(0, 16'd0, 16'd1000);
    clear[0] = 1'b1;
    in_valid[0] = 1'b1;
    prod[0] = 16'd5000;
    @(posedge clk);
    #1;
    clear[0] = 1'b0;
    in_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("clr_noout", 32'(out_valid[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    dot(0, 16'd32, 16'd1, 16'd2, 16'd3, 16'd4, 4, 8'h03, 1'b0);
    take(0, "clr_fresh");

    dot(0, 16'd0, 16'd100, 16'd100, 16'd100, 16'd100, 4, 8'h19, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ovalid", 32'(out_valid[0]), 32'd0);
    chk("arst_data", 32'(out_data[0]), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_irdy", 32'(in_ready[0]), 32'd1);
    chk("arst_noout", 32'(out_valid[0]), 32'd0);
    dot(0, 16'd0, 16'hFFCE, 16'hFFCE, 16'hFFCE, 16'hFFCE, 4, 8'hF4, 1'b0);
    take(0, "arst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
